decoder_seq: RTL and testbench



---
 rtl/decoder_pkg.sv | 17 +
 rtl/decoder_seq_dwell_timer.sv | 24 ++
 rtl/decoder_seq.sv | 125 ++++++++++++
 tb/tb_decoder_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared command-mode and FSM-state encodings for decoder_seq
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_ACCUM  = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/decoder_seq_dwell_timer.sv
// dwell_timer: loadable down-counter that rests at zero and flags expiry
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == '0);

  // Load wins; otherwise count down and hold once zero is reached.
  always_comb cnt_d = load ? load_val : (expire ? cnt_q : cnt_q - 1'b1);

  // Counter register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with direct, scan, accumulate and clear commands
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [1:0]              in_mode,
  input  logic [DWELL_W-1:0]      in_dwell,
  output logic [(1<<SEL_W)-1:0]   out_onehot,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 1 << SEL_W;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               ov_q, ov_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               t_load, t_expire;
  logic [DWELL_W-1:0] t_val;
  logic               accept;
  logic [SEL_W-1:0]   ptr_inc;
  logic [OUT_W-1:0]   sel_dec, inc_dec;
  mode_t              mode;

  assign accept   = in_valid && in_ready;
  assign mode     = mode_t'(in_mode);
  assign ptr_inc  = ptr_q + 1'b1;
  assign sel_dec  = OUT_W'(1) << in_sel;
  assign inc_dec  = OUT_W'(1) << ptr_inc;

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SCAN);
  assign done       = (state_q == ST_DONE);
  assign out_onehot = out_q;
  assign out_valid  = ov_q;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  // Next-state and datapath: commands only in IDLE; SCAN steps upward on timer expiry.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ov_d    = ov_q;
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    t_load  = 1'b0;
    t_val   = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (mode)
            MODE_DIRECT: begin
              out_d = sel_dec;
              ov_d  = 1'b1;
            end
            MODE_ACCUM: begin
              out_d = out_q | sel_dec;
              ov_d  = 1'b1;
            end
            MODE_CLEAR: begin
              out_d = '0;
              ov_d  = 1'b0;
            end
            MODE_SCAN: begin
              out_d   = sel_dec;
              ov_d    = 1'b1;
              ptr_d   = in_sel;
              dwell_d = in_dwell;
              t_load  = 1'b1;
              t_val   = in_dwell;
              state_d = ST_SCAN;
            end
          endcase
        end
      end
      ST_SCAN: begin
        if (t_expire) begin
          if (ptr_q == '1) begin
            state_d = ST_DONE;
          end else begin
            ptr_d  = ptr_inc;
            out_d  = inc_dec;
            t_load = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output, pointer and latched-dwell registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      ov_q    <= 1'b0;
      ptr_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed scoreboard bench for decoder_seq (default and SEL_W=4 instances)
module tb_decoder_seq;

  typedef struct packed {
    logic        d2;
    logic [15:0] oh;
    logic        ov;
    logic        bz;
    logic        dn;
    logic        rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v1 = 1'b0;
  logic [2:0]  sel1 = '0;
  logic [1:0]  mode1 = '0;
  logic [3:0]  dw1 = '0;
  logic        rdy1, ov1, bz1, dn1;
  logic [7:0]  oh1;
  logic        v2 = 1'b0;
  logic [3:0]  sel2 = '0;
  logic [1:0]  mode2 = '0;
  logic [1:0]  dw2 = '0;
  logic        rdy2, ov2, bz2, dn2;
  logic [15:0] oh2;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_seq dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_sel(sel1),
    .in_mode(mode1), .in_dwell(dw1), .out_onehot(oh1), .out_valid(ov1),
    .busy(bz1), .done(dn1)
  );

  decoder_seq #(.SEL_W(4), .DWELL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_sel(sel2),
    .in_mode(mode2), .in_dwell(dw2), .out_onehot(oh2), .out_valid(ov2),
    .busy(bz2), .done(dn2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic d2, input logic [15:0] oh, input logic ov,
                      input logic bz, input logic dn, input logic rdy);
    sb.push_back('{d2: d2, oh: oh, ov: ov, bz: bz, dn: dn, rdy: rdy});
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d2) begin
        chk("d2_onehot", 32'(oh2), 32'(e.oh));
        chk("d2_valid",  32'(ov2), 32'(e.ov));
        chk("d2_busy",   32'(bz2), 32'(e.bz));
        chk("d2_done",   32'(dn2), 32'(e.dn));
        chk("d2_ready",  32'(rdy2), 32'(e.rdy));
      end else begin
        chk("onehot", 32'(oh1), 32'(e.oh));
        chk("valid",  32'(ov1), 32'(e.ov));
        chk("busy",   32'(bz1), 32'(e.bz));
        chk("done",   32'(dn1), 32'(e.dn));
        chk("ready",  32'(rdy1), 32'(e.rdy));
      end
    end
  endtask

  task automatic cmd1(input logic [1:0] m, input logic [2:0] s, input logic [3:0] d);
    v1 = 1'b1; mode1 = m; sel1 = s; dw1 = d;
  endtask

  initial begin
    #2;
    chk("rst_onehot", 32'(oh1), 32'h0);
    chk("rst_valid",  32'(ov1), 32'h0);
    chk("rst_busy",   32'(bz1), 32'h0);
    chk("rst_done",   32'(dn1), 32'h0);
    #10 rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(rdy1), 32'h1);

    for (int i = 0; i < 8; i++) begin
      cmd1(2'b00, 3'(i), 4'd0);
      push(1'b0, 16'(1 << i), 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    v1 = 1'b0;

    cmd1(2'b01, 3'd5, 4'd2);
    push(1'b0, 16'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    v1 = 1'b0; sel1 = 3'd0; dw1 = 4'd9;
    for (int k = 1; k < 9; k++) begin
      push(1'b0, 16'(8'h20 << (k / 3)), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    push(1'b0, 16'h80, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    push(1'b0, 16'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    step();

    cmd1(2'b11, 3'd0, 4'd0);
    push(1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    cmd1(2'b10, 3'd1, 4'd0); push(1'b0, 16'h02, 1'b1, 1'b0, 1'b0, 1'b1); step();
    cmd1(2'b10, 3'd3, 4'd0); push(1'b0, 16'h0A, 1'b1, 1'b0, 1'b0, 1'b1); step();
    cmd1(2'b10, 3'd3, 4'd0); push(1'b0, 16'h0A, 1'b1, 1'b0, 1'b0, 1'b1); step();
    cmd1(2'b10, 3'd6, 4'd0); push(1'b0, 16'h4A, 1'b1, 1'b0, 1'b0, 1'b1); step();
    cmd1(2'b11, 3'd0, 4'd0); push(1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1); step();

    cmd1(2'b01, 3'd7, 4'd0);
    push(1'b0, 16'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    cmd1(2'b00, 3'd2, 4'd0);
    push(1'b0, 16'h80, 1'b1, 1'b0, 1'b1, 1'b0); step();
    push(1'b0, 16'h80, 1'b1, 1'b0, 1'b0, 1'b1); step();
    push(1'b0, 16'h04, 1'b1, 1'b0, 1'b0, 1'b1); step();
    v1 = 1'b0;

    cmd1(2'b01, 3'd0, 4'd15);
    push(1'b0, 16'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    v1 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      push(1'b0, 16'(1 << (k / 16)), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_onehot", 32'(oh1), 32'h0);
    chk("async_valid",  32'(ov1), 32'h0);
    chk("async_busy",   32'(bz1), 32'h0);
    chk("async_done",   32'(dn1), 32'h0);
    #3 rst_n = 1'b1;
    push(1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    v2 = 1'b1; mode2 = 2'b01; sel2 = 4'd14; dw2 = 2'd1;
    push(1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    v2 = 1'b0;
    push(1'b1, 16'h4000, 1'b1, 1'b1, 1'b0, 1'b0); step();
    push(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0); step();
    push(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0); step();
    push(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0); step();
    push(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1); step();

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
